// File: rtl/wb_ram_arbiter_if.sv
// Wishbone pipelined bus bundle used between the masters, the arbiter and the RAM slave.
//   master modport : drives cyc/stb/we/adr/dat_w/sel, receives dat_r/ack/err/rty/stall
//   slave modport  : the mirror image
// dat_w is master-to-slave write data, dat_r is slave-to-master read data.
interface wb_ram_arbiter_if #(
    parameter int unsigned ADR_W = 32,
    parameter int unsigned DAT_W = 32
);
    localparam int unsigned SEL_W = DAT_W / 8;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_w;
    logic [SEL_W-1:0] sel;
    logic [DAT_W-1:0] dat_r;
    logic             ack;
    logic             err;
    logic             rty;
    logic             stall;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err, rty, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err, rty, stall
    );
endinterface

// File: rtl/wb_ram_arbiter.sv
// Two-master, one-slave Wishbone pipelined arbiter in front of the RAM controller.
// Round-robin grant held for the whole bus cycle (while the granted cyc stays high).
//   clk_bus / rst_bus : bus clock, asynchronous active-high reset
//   m0_io, m1_io      : master ports (instruction fetch, data), slave modport
//   s_io              : port towards the RAM slave, master modport
// Optional response watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_ram_arbiter #(
    parameter int unsigned ADR_W          = 32,
    parameter int unsigned DAT_W          = 32,
    parameter int unsigned OUTST_W        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk_bus,
    input  logic             rst_bus,
    wb_ram_arbiter_if.slave  m0_io,
    wb_ram_arbiter_if.slave  m1_io,
    wb_ram_arbiter_if.master s_io
);
    localparam int unsigned SEL_W = DAT_W / 8;
    localparam logic [OUTST_W-1:0] OutstMax = '1;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;   // 0: m0 served last, 1: m1 served last
    logic [OUTST_W-1:0] outst_q, outst_d;
    logic               rel;              // granted master dropped cyc this cycle
    logic               sat;
    logic               inc, dec, resp;
    logic               timeout;

    logic               cyc_mux, stb_mux, we_mux;
    logic [ADR_W-1:0]   adr_mux;
    logic [DAT_W-1:0]   wdat_mux;
    logic [SEL_W-1:0]   sel_mux;

    // Grant FSM
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        rel     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (m0_io.cyc && (!m1_io.cyc || last_q)) begin
                    state_d = StGnt0;
                end else if (m1_io.cyc) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!m0_io.cyc) begin
                    rel     = 1'b1;
                    last_d  = 1'b0;
                    state_d = m1_io.cyc ? StGnt1 : StIdle;
                end
            end
            StGnt1: begin
                if (!m1_io.cyc) begin
                    rel     = 1'b1;
                    last_d  = 1'b1;
                    state_d = m0_io.cyc ? StGnt0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Request path
    always_comb begin
        cyc_mux  = 1'b0;
        stb_mux  = 1'b0;
        we_mux   = 1'b0;
        adr_mux  = '0;
        wdat_mux = '0;
        sel_mux  = '0;
        unique case (state_q)
            StGnt0: begin
                cyc_mux  = m0_io.cyc;
                stb_mux  = m0_io.stb;
                we_mux   = m0_io.we;
                adr_mux  = m0_io.adr;
                wdat_mux = m0_io.dat_w;
                sel_mux  = m0_io.sel;
            end
            StGnt1: begin
                cyc_mux  = m1_io.cyc;
                stb_mux  = m1_io.stb;
                we_mux   = m1_io.we;
                adr_mux  = m1_io.adr;
                wdat_mux = m1_io.dat_w;
                sel_mux  = m1_io.sel;
            end
            default: ;
        endcase
    end

    assign s_io.cyc   = cyc_mux;
    assign s_io.stb   = stb_mux;
    assign s_io.we    = we_mux;
    assign s_io.adr   = adr_mux;
    assign s_io.dat_w = wdat_mux;
    assign s_io.sel   = sel_mux;

    // Response path: only the grantee sees the slave, everyone else is stalled
    always_comb begin
        m0_io.dat_r = '0;
        m0_io.ack   = 1'b0;
        m0_io.err   = 1'b0;
        m0_io.rty   = 1'b0;
        m0_io.stall = 1'b1;
        m1_io.dat_r = '0;
        m1_io.ack   = 1'b0;
        m1_io.err   = 1'b0;
        m1_io.rty   = 1'b0;
        m1_io.stall = 1'b1;
        if (state_q == StGnt0) begin
            m0_io.dat_r = s_io.dat_r;
            m0_io.ack   = s_io.ack;
            m0_io.err   = s_io.err | timeout;
            m0_io.rty   = s_io.rty;
            m0_io.stall = s_io.stall | sat;
        end else if (state_q == StGnt1) begin
            m1_io.dat_r = s_io.dat_r;
            m1_io.ack   = s_io.ack;
            m1_io.err   = s_io.err | timeout;
            m1_io.rty   = s_io.rty;
            m1_io.stall = s_io.stall | sat;
        end
    end

    // Outstanding-request counter; a stale response at zero is not allowed to underflow
    assign sat  = (outst_q == OutstMax);
    assign resp = s_io.ack | s_io.err | s_io.rty;
    assign inc  = s_io.stb & ~s_io.stall;
    assign dec  = resp & (outst_q != '0);

    always_comb begin
        outst_d = outst_q;
        if (state_q == StIdle || rel || timeout) begin
            outst_d = '0;
        end else if (inc && !dec) begin
            if (!sat) begin
                outst_d = outst_q + 1'b1;
            end
        end else if (dec && !inc) begin
            outst_d = outst_q - 1'b1;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wdog_q, wdog_d;

    // Fires in the TIMEOUT_CYCLES-th cycle with a request pending and no response
    assign timeout = (outst_q != '0) && !resp && (wdog_q == WdLast);

    always_comb begin
        wdog_d = wdog_q + 1'b1;
        if (rel || timeout || resp || outst_q == '0) begin
            wdog_d = '0;
        end
    end

    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            outst_q <= outst_d;
        end
    end
endmodule
